// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare direction predictor.
// Counters are 2-bit saturating: values 0/1 predict not-taken, 2/3 predict taken.
package bp_pkg;

   typedef logic [1:0] pht_ctr_t;

   localparam pht_ctr_t CTR_SNT = 2'd0;
   localparam pht_ctr_t CTR_WNT = 2'd1;
   localparam pht_ctr_t CTR_WT  = 2'd2;
   localparam pht_ctr_t CTR_ST  = 2'd3;

   function automatic pht_ctr_t sat_update(input pht_ctr_t ctr, input logic taken);
      pht_ctr_t res;
      res = ctr;
      if (taken) begin
         if (ctr != CTR_ST) res = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) res = ctr - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/gshare_predictor_ghr_unit.sv
// Global history register: speculative shift at fetch, repaired from the EX snapshot.
// A mispredict repair outranks the fetch-side shift arriving in the same cycle.
module ghr_unit #(
   parameter int hist_len = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ex_mispredict,
   input  logic                ex_taken,
   input  logic [hist_len-1:0] ex_ghr,
   input  logic                if_shift,
   input  logic                if_pred_taken,
   output logic [hist_len-1:0] ghr
);

   logic [hist_len-1:0] ghr_next;

   // Cast-truncation drops the oldest bit and covers hist_len = 1 without a slice.
   function automatic logic [hist_len-1:0] shift_in(input logic [hist_len-1:0] h, input logic b);
      return hist_len'({h, b});
   endfunction

   always_comb begin
      ghr_next = ghr;
      if (ex_mispredict) ghr_next = shift_in(ex_ghr, ex_taken);
      else if (if_shift) ghr_next = shift_in(ghr, if_pred_taken);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ghr <= '0;
      else      ghr <= ghr_next;
   end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare predictor: PHT of 2-bit counters indexed by PC xor global history,
// trained from EX, with BTB handoff signals and saturating perf counters.
module gshare_predictor
   import bp_pkg::*;
#(
   parameter int s_index  = 4,
   parameter int hist_len = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         if_pc_in,
   input  logic                if_is_br,
   input  logic                if_stall,
   output logic                if_pred_taken,
   output logic [hist_len-1:0] if_ghr,
   input  logic [31:0]         ex_pc_in,
   input  logic                ex_br_valid,
   input  logic                ex_taken,
   input  logic [31:0]         ex_target,
   input  logic [hist_len-1:0] ex_ghr,
   input  logic                ex_pred_taken,
   output logic                ex_mispredict,
   output logic                update,
   output logic                update_btb,
   output logic                p_tnt,
   output logic [31:0]         br_out,
   output logic [31:0]         br_count,
   output logic [31:0]         mp_count
);

   localparam int num_sets = 2 ** s_index;

   pht_ctr_t            pht [num_sets];
   logic [hist_len-1:0] ghr;
   logic [s_index-1:0]  if_idx;
   logic [s_index-1:0]  ex_idx;
   pht_ctr_t            ex_ctr_next;
   logic                mispredict_raw;
   logic [31:0]         br_count_q;
   logic [31:0]         mp_count_q;
   logic                unused_pc_bits;

   assign if_idx = if_pc_in[s_index+1:2] ^ s_index'(ghr);
   assign ex_idx = ex_pc_in[s_index+1:2] ^ s_index'(ex_ghr);

   assign if_pred_taken = pht[if_idx][1];
   assign if_ghr        = ghr;

   assign mispredict_raw = ex_br_valid & (ex_taken != ex_pred_taken);
   assign ex_ctr_next    = sat_update(pht[ex_idx], ex_taken);

   // EX handoff is combinational but held at zero while reset is asserted.
   assign ex_mispredict = rst & mispredict_raw;
   assign update        = rst & ex_br_valid;
   assign update_btb    = rst & ex_br_valid & ex_taken;
   assign p_tnt         = rst & ex_ctr_next[1];
   assign br_out        = rst ? ex_target : 32'd0;

   assign br_count = br_count_q;
   assign mp_count = mp_count_q;

   assign unused_pc_bits = ^{if_pc_in[31:s_index+2], if_pc_in[1:0],
                             ex_pc_in[31:s_index+2], ex_pc_in[1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < num_sets; i++) pht[i] <= CTR_WNT;
      end else if (ex_br_valid) begin
         pht[ex_idx] <= ex_ctr_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         br_count_q <= '0;
         mp_count_q <= '0;
      end else begin
         if (ex_br_valid && (br_count_q != 32'hFFFF_FFFF)) br_count_q <= br_count_q + 32'd1;
         if (mispredict_raw && (mp_count_q != 32'hFFFF_FFFF)) mp_count_q <= mp_count_q + 32'd1;
      end
   end

   ghr_unit #(.hist_len(hist_len)) u_ghr (
      .clk           (clk),
      .rst           (rst),
      .ex_mispredict (mispredict_raw),
      .ex_taken      (ex_taken),
      .ex_ghr        (ex_ghr),
      .if_shift      (if_is_br & ~if_stall),
      .if_pred_taken (if_pred_taken),
      .ghr           (ghr)
   );

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: table vectors, directed corner
// sequences and random traffic, all checked against an array-based model.
module tb_gshare_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc_in;
   logic        if_is_br, if_stall, if_pred_taken;
   logic [3:0]  if_ghr;
   logic [31:0] ex_pc_in, ex_target, br_out, br_count, mp_count;
   logic        ex_br_valid, ex_taken, ex_pred_taken;
   logic [3:0]  ex_ghr;
   logic        ex_mispredict, update, update_btb, p_tnt;

   gshare_predictor #(.s_index(4), .hist_len(4)) dut (
      .clk(clk), .rst(rst),
      .if_pc_in(if_pc_in), .if_is_br(if_is_br), .if_stall(if_stall),
      .if_pred_taken(if_pred_taken), .if_ghr(if_ghr),
      .ex_pc_in(ex_pc_in), .ex_br_valid(ex_br_valid), .ex_taken(ex_taken),
      .ex_target(ex_target), .ex_ghr(ex_ghr), .ex_pred_taken(ex_pred_taken),
      .ex_mispredict(ex_mispredict), .update(update), .update_btb(update_btb),
      .p_tnt(p_tnt), .br_out(br_out), .br_count(br_count), .mp_count(mp_count)
   );

   always #5 clk = ~clk;

   int      checks = 0;
   int      failures = 0;
   int      pht_m [16];
   int      ghr_m;
   longint  brc_m, mpc_m;
   logic    s_pred, s_ptnt, s_mp, s_upd, s_btb;
   logic [3:0]  s_ghr;
   logic [31:0] s_brout;

   typedef struct {
      logic        v, tk, pr;
      logic [31:0] tgt;
      logic        e_mp, e_upd, e_btb;
   } vec_t;
   vec_t tbl [5];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int idx(input logic [31:0] pc, input int h);
      return int'((pc >> 2) & 32'hF) ^ (h & 15);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) pht_m[i] = 1;
      ghr_m = 0;
      brc_m = 0;
      mpc_m = 0;
   endtask

   task automatic idle();
      if_pc_in = 0; if_is_br = 0; if_stall = 0;
      ex_pc_in = 0; ex_br_valid = 0; ex_taken = 0; ex_target = 0;
      ex_ghr = 0; ex_pred_taken = 0;
   endtask

   task automatic step(input logic [31:0] ipc, input logic ibr, input logic istall,
                       input logic [31:0] epc, input logic ev, input logic etk,
                       input logic [31:0] etgt, input logic [3:0] eg, input logic ep);
      int ii, ei, c, nc;
      bit pm, mp;
      @(negedge clk);
      if_pc_in = ipc; if_is_br = ibr; if_stall = istall;
      ex_pc_in = epc; ex_br_valid = ev; ex_taken = etk; ex_target = etgt;
      ex_ghr = eg; ex_pred_taken = ep;
      #1;
      ii = idx(ipc, ghr_m);
      pm = (pht_m[ii] >= 2);
      mp = ev && (etk != ep);
      ei = idx(epc, int'(eg));
      c  = pht_m[ei];
      nc = etk ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
      chk("if_pred_taken", if_pred_taken, pm);
      chk("if_ghr", if_ghr, ghr_m);
      chk("ex_mispredict", ex_mispredict, mp);
      chk("update", update, ev);
      chk("update_btb", update_btb, ev && etk);
      chk("br_out", br_out, etgt);
      if (ev) chk("p_tnt", p_tnt, nc >= 2);
      chk("br_count", br_count, brc_m);
      chk("mp_count", mp_count, mpc_m);
      s_pred = if_pred_taken; s_ghr = if_ghr; s_ptnt = p_tnt;
      s_mp = ex_mispredict; s_upd = update; s_btb = update_btb; s_brout = br_out;
      if (ev) pht_m[ei] = nc;
      if (mp) ghr_m = ((int'(eg) << 1) | int'(etk)) & 15;
      else if (ibr && !istall) ghr_m = ((ghr_m << 1) | int'(pm)) & 15;
      if (ev && brc_m != 64'hFFFF_FFFF) brc_m++;
      if (mp && mpc_m != 64'hFFFF_FFFF) mpc_m++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      tbl[0] = '{v:1, tk:0, pr:0, tgt:32'h200, e_mp:0, e_upd:1, e_btb:0};
      tbl[1] = '{v:1, tk:1, pr:0, tgt:32'h200, e_mp:1, e_upd:1, e_btb:1};
      tbl[2] = '{v:0, tk:1, pr:0, tgt:32'h300, e_mp:0, e_upd:0, e_btb:0};
      tbl[3] = '{v:1, tk:1, pr:1, tgt:32'h400, e_mp:0, e_upd:1, e_btb:1};
      tbl[4] = '{v:1, tk:0, pr:1, tgt:32'h500, e_mp:1, e_upd:1, e_btb:0};

      idle();
      rst = 1'b0;
      model_reset();
      #3;
      chk("reset_pred", if_pred_taken, 0);
      chk("reset_ghr", if_ghr, 0);
      chk("reset_br_count", br_count, 0);
      chk("reset_mp_count", mp_count, 0);
      @(negedge clk);
      rst = 1'b1;

      // BTB handoff table
      for (int i = 0; i < 5; i++) begin
         step(32'h0, 0, 0, 32'h40 + 32'(i * 4), tbl[i].v, tbl[i].tk, tbl[i].tgt, 4'd0, tbl[i].pr);
         chk("tbl_mispredict", s_mp, tbl[i].e_mp);
         chk("tbl_update", s_upd, tbl[i].e_upd);
         chk("tbl_update_btb", s_btb, tbl[i].e_btb);
         chk("tbl_br_out", s_brout, tbl[i].tgt);
      end

      // Saturation up and down at pc 0x100, history 0
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(32'h0, 0, 0, 32'h100, 1, 1, 32'h0, 4'd0, 1);
         chk("sat_up_p_tnt", s_ptnt, 1);
      end
      step(32'h100, 0, 0, 32'h0, 0, 0, 32'h0, 4'd0, 0);
      chk("sat_lookup_taken", s_pred, 1);
      step(32'h0, 0, 0, 32'h100, 1, 0, 32'h0, 4'd0, 0);
      chk("sat_dn1_p_tnt", s_ptnt, 1);
      step(32'h0, 0, 0, 32'h100, 1, 0, 32'h0, 4'd0, 0);
      chk("sat_dn2_p_tnt", s_ptnt, 0);
      step(32'h0, 0, 0, 32'h100, 1, 0, 32'h0, 4'd0, 0);
      chk("sat_dn3_p_tnt", s_ptnt, 0);
      step(32'h100, 0, 0, 32'h0, 0, 0, 32'h0, 4'd0, 0);
      chk("sat_lookup_nt", s_pred, 0);

      // Retrain index 0 to strongly taken, then speculative shifts 1,0,1 and a stall
      for (int i = 0; i < 3; i++) step(32'h0, 0, 0, 32'h100, 1, 1, 32'h0, 4'd0, 1);
      step(32'h100, 1, 0, 32'h0, 0, 0, 32'h0, 4'd0, 0);
      chk("spec_ghr0", s_ghr, 4'h0);
      chk("spec_pred1", s_pred, 1);
      step(32'h100, 1, 0, 32'h0, 0, 0, 32'h0, 4'd0, 0);
      chk("spec_ghr1", s_ghr, 4'h1);
      chk("spec_pred2", s_pred, 0);
      step(32'h108, 1, 0, 32'h0, 0, 0, 32'h0, 4'd0, 0);
      chk("spec_ghr2", s_ghr, 4'h2);
      chk("spec_pred3", s_pred, 1);
      step(32'h0, 1, 1, 32'h0, 0, 0, 32'h0, 4'd0, 0);
      chk("spec_ghr5", s_ghr, 4'h5);
      step(32'h114, 0, 0, 32'h0, 0, 0, 32'h0, 4'd0, 0);
      chk("stall_hold_ghr", s_ghr, 4'h5);
      chk("pre_reset_pred", s_pred, 1);

      // Asynchronous reset in the middle of a cycle with a training write pending
      ex_pc_in = 32'h114; ex_br_valid = 1; ex_taken = 1; ex_ghr = 4'h5; ex_pred_taken = 0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("async_pred", if_pred_taken, 0);
      chk("async_ghr", if_ghr, 0);
      chk("async_br_count", br_count, 0);
      chk("async_update", update, 0);
      chk("async_mispredict", ex_mispredict, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      idle();
      rst = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step(32'h100 + 32'(i * 4), 0, 0, 32'h0, 0, 0, 32'h0, 4'd0, 0);
         chk("post_reset_nt", s_pred, 0);
      end

      // Recovery beats the speculative shift in the same cycle
      step(32'h0, 0, 0, 32'h100, 1, 1, 32'h0, 4'h5, 0);
      step(32'h38, 1, 0, 32'h200, 1, 1, 32'h0, 4'h6, 0);
      chk("rec_ghr_before", s_ghr, 4'hB);
      chk("rec_if_pred", s_pred, 1);
      step(32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 4'd0, 0);
      chk("rec_ghr_after", s_ghr, 4'hD);

      // Aliasing: 0x104/ghr0 and 0x100/ghr1 share index 1
      do_reset();
      step(32'h0, 0, 0, 32'h104, 1, 1, 32'h0, 4'h0, 1);
      chk("alias_a", s_ptnt, 1);
      step(32'h0, 0, 0, 32'h100, 1, 1, 32'h0, 4'h1, 1);
      chk("alias_b", s_ptnt, 1);
      step(32'h0, 0, 0, 32'h104, 1, 0, 32'h0, 4'h0, 0);
      chk("alias_c", s_ptnt, 1);

      // Same-entry read during write sees the old counter
      step(32'h100, 0, 0, 32'h100, 1, 1, 32'h0, 4'h0, 1);
      chk("rw_old", s_pred, 0);
      step(32'h100, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 0);
      chk("rw_new", s_pred, 1);

      // Branch counter saturation from a preloaded value
      @(negedge clk);
      idle();
      force dut.br_count_q = 32'hFFFF_FFFE;
      #1;
      release dut.br_count_q;
      brc_m = 64'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) step(32'h0, 0, 0, 32'h180, 1, 1, 32'h0, 4'h0, 1);
      step(32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 0);
      chk("br_count_sat", br_count, 64'hFFFF_FFFF);

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step(32'h100 + 32'($urandom_range(0, 15) * 4), 1'($urandom), 1'($urandom_range(0, 3) == 0),
              32'h100 + 32'($urandom_range(0, 15) * 4), 1'($urandom), 1'($urandom),
              $urandom, 4'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Direction predictor directly upstream of the BTB in the fetch/execute branch path.
- IF side: indexes a pattern history table (PHT) of 2-bit saturating counters with PC XOR global history. Returns a taken/not-taken guess and a history snapshot that travels down the pipeline.
- EX side: trains the PHT on resolved branches, drives the BTB's update/update_btb/p_tnt/br_out inputs, and repairs speculative history on a mispredict.

Parameters:
- s_index, 4, PHT index bits; num_sets = 2**s_index. Must match the BTB's s_index.
- hist_len, 4, global history register (GHR) width; legal range is 1..s_index.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- if_pc_in  in  32  fetch PC.
- if_is_br  in  1  BTB reports a branch at if_pc_in (BTB btb_flag[1]).
- if_stall  in  1  fetch held this cycle.
- if_pred_taken  out  1  direction guess for if_pc_in.
- if_ghr  out  hist_len  GHR snapshot used for this lookup; the pipeline carries it to EX.
- ex_pc_in  in  32  PC of the branch resolving in EX.
- ex_br_valid  in  1  a conditional branch resolves this cycle.
- ex_taken  in  1  actual outcome.
- ex_target  in  32  computed branch target.
- ex_ghr  in  hist_len  snapshot carried from IF.
- ex_pred_taken  in  1  guess carried from IF.
- ex_mispredict  out  1  resolved outcome differs from the guess.
- update  out  1  to BTB: write the predict bit.
- update_btb  out  1  to BTB: write br_pc/target.
- p_tnt  out  1  to BTB: new predict bit.
- br_out  out  32  to BTB: target.
- br_count  out  32  resolved branches, saturating.
- mp_count  out  32  mispredicts, saturating.

Behaviour:
- **Reset (rst=0, async):**
  - All PHT entries go to 2'b01 (weakly not-taken).
  - GHR goes to 0; br_count and mp_count go to 0.
  - Consequently if_pred_taken = 0 and if_ghr = 0 while in reset.
  - EX outputs are combinational from EX inputs and are additionally forced to 0 while rst=0.
- **Index:**
  - idx(pc, h) = pc[s_index+1:2] XOR zero-extend(h to s_index bits).
- **IF lookup (combinational, 0-cycle):**
  - if_pred_taken = PHT[idx(if_pc_in, GHR)][1].
  - if_ghr = GHR.
- **EX combinational outputs:**
  - ex_mispredict = ex_br_valid & (ex_taken != ex_pred_taken).
  - update = ex_br_valid.
  - update_btb = ex_br_valid & ex_taken.
  - br_out = ex_target.
  - p_tnt = bit 1 of the post-training counter value.
- **PHT training (at posedge, when ex_br_valid):**
  - c = PHT[idx(ex_pc_in, ex_ghr)].
  - If taken: c = min(c+1, 3). If not taken: c = max(c-1, 0). Saturation is at 3 and at 0; no wrap.
- **GHR next-state, priority order:**
  1. If ex_mispredict: GHR <= {ex_ghr[hist_len-2:0], ex_taken}. When hist_len = 1, GHR <= ex_taken.
  2. Else if if_is_br & ~if_stall: GHR <= {GHR[hist_len-2:0], if_pred_taken}.
  3. Else: hold.
- **Simultaneous events:**
  - Recovery overrides the speculative IF shift in the same cycle.
  - A correctly predicted EX branch leaves the GHR untouched, because it was already shifted at IF.
- **Same-entry read/write:**
  - An IF lookup in the cycle of a write to the same entry sees the old value.
  - The new value is visible the next cycle; no bypass.
- **Performance counters:**
  - br_count += 1 on ex_br_valid; mp_count += 1 on ex_mispredict.
  - Both hold at 32'hFFFF_FFFF once reached.
- **Reset mid-operation:**
  - Any in-flight training write is dropped.
  - All state returns to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package (bp_pkg) holds:
  - counter type pht_ctr_t (2-bit);
  - constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3;
  - function sat_update(pht_ctr_t, logic taken).
- One natural sub-module, ghr_unit: GHR register with speculative shift, recovery, and priority logic.
- PHT array, index hashing, and performance counters stay in gshare_predictor.

Test Plan:
- **Reset:** drop rst to 0 mid-cycle → if_pred_taken = 0, if_ghr = 0, br_count = 0, all immediately without a clock edge. After release, every PC predicts not-taken.
- **Saturation:** pc = 0x100, ex_ghr = 0, four taken resolutions → counter goes 01→10→11→11. p_tnt = 1 from the first update onward; next IF lookup of 0x100 with GHR = 0 gives 1. Then three not-taken → 10, 01, 00; p_tnt = 1, 0, 0.
- **Speculative shift:** GHR = 0, if_is_br = 1 with guesses 1, 0, 1 on consecutive unstalled cycles → GHR = 0001, 0010, 0101. With if_stall = 1 the GHR holds.
- **Recovery priority:** GHR = 1011, same cycle: ex_mispredict with ex_ghr = 0110 and ex_taken = 1, plus IF branch predicted 1 → GHR = 1101. IF shift ignored.
- **BTB handoff:** ex_br_valid = 1, ex_taken = 0, ex_target = 0x200 → update = 1, update_btb = 0, br_out = 0x200. With ex_taken = 1 → update_btb = 1.
- **Counters and aliasing:** preload br_count to 32'hFFFF_FFFE, resolve 3 branches → count holds at 32'hFFFF_FFFF. Train PCs 0x104 (GHR 0) and 0x100 (GHR 1), which share index 1 → both observe the same counter.
